// File: rtl/routing_state_if.sv
// Shared types and the bundle between the system-flit decoder side and
// routing_state_reg.
//
// routing_state_pkg
//   node_id_t       : 6-bit node identifier; all-ones is the broadcast ID.
//   routing_table_t : per-destination valid/next-hop table plus parent and
//                     own-ID registers, exported as one packed word.
//
// routing_state_if
//   master : decoder / flit-path side. Drives the straps, update strobes and
//            join_req_ready. Observes the registered routing state.
//   slave  : routing_state_reg.
//   Optional table_clear exists only when ROUTING_TABLE_CLEAR_EN is defined.

package routing_state_pkg;
    localparam int       NODE_ID_W = 6;
    localparam int       NUM_NODES = 1 << NODE_ID_W;

    typedef logic [NODE_ID_W-1:0] node_id_t;

    localparam node_id_t BROADCAST_ID = '1;
    localparam node_id_t LAST_ID      = BROADCAST_ID - node_id_t'(1);

    typedef struct packed {
        logic     [NUM_NODES-1:0] valid;
        node_id_t [NUM_NODES-1:0] next_hop;
        logic                     parent_valid;
        node_id_t                 parent_node_id;
        logic                     this_node_valid;
        node_id_t                 this_node_id;
    } routing_table_t;
endpackage

interface routing_state_if;
    import routing_state_pkg::*;

    logic           is_root;
    node_id_t       random_id;
    logic           join_start;
    logic           update_parent_valid;
    node_id_t       update_parent_node_id;
    logic           update_this_node_valid;
    node_id_t       update_this_node_id;
    logic           update_routing_table_valid;
    node_id_t       update_routing_table_key;
    node_id_t       update_routing_table_value;
    logic           update_routing_id_counter_valid;
`ifdef ROUTING_TABLE_CLEAR_EN
    logic           table_clear;
`endif
    logic           join_req_valid;
    logic           join_req_ready;
    routing_table_t routing_table;
    node_id_t       temporal_id;
    node_id_t       routing_id_counter;
    logic           joined;
    logic           join_fail;
    logic           table_full;

    modport master (
`ifdef ROUTING_TABLE_CLEAR_EN
        output table_clear,
`endif
        output is_root, random_id, join_start,
        output update_parent_valid, update_parent_node_id,
        output update_this_node_valid, update_this_node_id,
        output update_routing_table_valid, update_routing_table_key,
        output update_routing_table_value, update_routing_id_counter_valid,
        output join_req_ready,
        input  join_req_valid, routing_table, temporal_id,
        input  routing_id_counter, joined, join_fail, table_full
    );

    modport slave (
`ifdef ROUTING_TABLE_CLEAR_EN
        input  table_clear,
`endif
        input  is_root, random_id, join_start,
        input  update_parent_valid, update_parent_node_id,
        input  update_this_node_valid, update_this_node_id,
        input  update_routing_table_valid, update_routing_table_key,
        input  update_routing_table_value, update_routing_id_counter_valid,
        input  join_req_ready,
        output join_req_valid, routing_table, temporal_id,
        output routing_id_counter, joined, join_fail, table_full
    );
endinterface

// File: rtl/routing_state_reg.sv
// routing_state_reg: registered routing state of a node, downstream of the
// system-flit decoder. Holds the routing table, parent, own node ID and the
// root's ID counter, and runs the join sequence for non-root nodes
// (request parent -> wait for ID -> time out and retry -> fail).
//
// Ports
//   clk, rst : clock, asynchronous active-high reset
//   bus      : routing_state_if.slave (straps, update strobes, join request
//              handshake, registered state back to the decoder)
//
// Parameters
//   ACK_TIMEOUT : cycles spent in WAIT before an attempt is abandoned
//   MAX_RETRY   : retries after the first attempt before FAILED
//
// Optional feature (macro ROUTING_TABLE_CLEAR_EN): adds bus.table_clear, a
// synchronous pulse that drops every table entry and the parent.

// One routing-table slot. Clear wins over a same-cycle write.
module routing_table_entry
    import routing_state_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    input  logic     wr_en,
    input  logic     clr,
    input  node_id_t wr_value,
    output logic     valid,
    output node_id_t next_hop
);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid    <= 1'b0;
            next_hop <= '0;
        end else if (clr) begin
            valid    <= 1'b0;
        end else if (wr_en) begin
            valid    <= 1'b1;
            next_hop <= wr_value;
        end
    end
endmodule

module routing_state_reg
    import routing_state_pkg::*;
#(
    parameter int ACK_TIMEOUT = 1024,
    parameter int MAX_RETRY   = 3
) (
    input logic            clk,
    input logic            rst,
    routing_state_if.slave bus
);
    localparam int TMR_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam int RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQUEST,
        ST_WAIT,
        ST_JOINED,
        ST_FAILED
    } state_t;

    state_t             state_q, state_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic [RTY_W-1:0]   retry_q, retry_d;
    logic               latch_id;
    logic               drop_parent;

    logic               parent_valid_q;
    node_id_t           parent_id_q;
    logic               this_valid_q;
    node_id_t           this_id_q;
    node_id_t           temporal_q;
    node_id_t           counter_q;
    logic               table_full_q;

    logic               tbl_clr;
    logic               tbl_wr_ok;
    logic               parent_wr;
    logic               own_wr;
    logic [NUM_NODES-1:0] tbl_valid;
    node_id_t [NUM_NODES-1:0] tbl_hop;

`ifdef ROUTING_TABLE_CLEAR_EN
    assign tbl_clr = bus.table_clear;
`else
    assign tbl_clr = 1'b0;
`endif

    // Key 0 and the broadcast ID are never legal destinations.
    assign tbl_wr_ok = bus.update_routing_table_valid
                    && (bus.update_routing_table_key != '0)
                    && (bus.update_routing_table_key != BROADCAST_ID);

    // First parent ack of an attempt wins; later ones are dropped.
    assign parent_wr = (state_q == ST_WAIT) && !parent_valid_q && bus.update_parent_valid;
    assign own_wr    = (state_q == ST_WAIT) && !bus.is_root && bus.update_this_node_valid;

    for (genvar i = 0; i < NUM_NODES; i++) begin : g_entry
        routing_table_entry u_entry (
            .clk      (clk),
            .rst      (rst),
            .wr_en    (tbl_wr_ok && (bus.update_routing_table_key == node_id_t'(i))),
            .clr      (tbl_clr),
            .wr_value (bus.update_routing_table_value),
            .valid    (tbl_valid[i]),
            .next_hop (tbl_hop[i])
        );
    end

    // ---------------- join FSM ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= bus.is_root ? ST_JOINED : ST_IDLE;
            timer_q <= '0;
            retry_q <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            retry_q <= retry_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        retry_d     = retry_q;
        latch_id    = 1'b0;
        drop_parent = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.join_start) begin
                    latch_id = 1'b1;
                    retry_d  = '0;
                    state_d  = ST_REQUEST;
                end
            end
            ST_REQUEST: begin
                if (bus.join_req_ready) begin
                    timer_d = '0;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                timer_d = timer_q + 1'b1;
                // An ID arriving on the timeout cycle still completes the join.
                if (own_wr) begin
                    state_d = ST_JOINED;
                end else if (timer_q == TMR_W'(ACK_TIMEOUT - 1)) begin
                    if (retry_q < RTY_W'(MAX_RETRY)) begin
                        drop_parent = 1'b1;
                        latch_id    = 1'b1;
                        retry_d     = retry_q + 1'b1;
                        state_d     = ST_REQUEST;
                    end else begin
                        state_d     = ST_FAILED;
                    end
                end
            end
            ST_JOINED: ;
            ST_FAILED: begin
                if (bus.join_start) begin
                    drop_parent = 1'b1;
                    latch_id    = 1'b1;
                    retry_d     = '0;
                    state_d     = ST_REQUEST;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // ---------------- parent / own ID / counter ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            parent_valid_q <= 1'b0;
            parent_id_q    <= '0;
            this_valid_q   <= bus.is_root;
            this_id_q      <= '0;
            temporal_q     <= '0;
            counter_q      <= bus.is_root ? node_id_t'(1) : '0;
            table_full_q   <= 1'b0;
        end else begin
            if (latch_id)
                temporal_q <= bus.random_id;

            // A fresh attempt or a table clear forgets the old parent.
            if (drop_parent || tbl_clr) begin
                parent_valid_q <= 1'b0;
            end else if (parent_wr) begin
                parent_valid_q <= 1'b1;
                parent_id_q    <= bus.update_parent_node_id;
            end

            if (own_wr) begin
                this_valid_q <= 1'b1;
                this_id_q    <= bus.update_this_node_id;
            end

            // LAST_ID is still handed out; full means a request past it.
            if (bus.is_root && bus.update_routing_id_counter_valid) begin
                if (counter_q == LAST_ID)
                    table_full_q <= 1'b1;
                else
                    counter_q    <= counter_q + 1'b1;
            end
        end
    end

    assign bus.routing_table = '{
        valid:           tbl_valid,
        next_hop:        tbl_hop,
        parent_valid:    parent_valid_q,
        parent_node_id:  parent_id_q,
        this_node_valid: this_valid_q,
        this_node_id:    this_id_q
    };

    assign bus.temporal_id        = temporal_q;
    assign bus.routing_id_counter = counter_q;
    assign bus.join_req_valid     = (state_q == ST_REQUEST);
    assign bus.joined             = (state_q == ST_JOINED);
    assign bus.join_fail          = (state_q == ST_FAILED);
    assign bus.table_full         = table_full_q;
endmodule
